// File: rtl/clk_div_bank.sv
// Multi-channel divided-clock / tick generator gated by a debounced PLL lock.
// All channels restart in phase on entry to RUN and on a resync request.
`timescale 1ns/1ps
module clk_div_bank #(
    parameter int unsigned CH        = 4,
    parameter int unsigned W         = 16,
    parameter int unsigned LOCK_WAIT = 1024
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              resync,
    input  logic [CH*W-1:0]   div_val,
    output logic [CH-1:0]     div_clk,
    output logic [CH-1:0]     tick,
    output logic              ready,
    output logic              lock_lost
);

    localparam int unsigned SW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_WAIT - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } state_t;

    state_t        state, state_nx;
    logic [SW-1:0] settle_cnt, settle_nx;
    logic          lk_m, lk_s;
    logic          lost_nx;

    logic [W-1:0]  cnt     [CH];
    logic [W-1:0]  dact    [CH];
    logic [W-1:0]  cnt_nx  [CH];
    logic [W-1:0]  dact_nx [CH];
    logic [W-1:0]  half_nx [CH];
    logic [CH-1:0] clk_nx;
    logic [CH-1:0] tick_nx;

    always_comb begin
        state_nx  = state;
        settle_nx = settle_cnt;
        case (state)
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_nx  = SETTLE;
                    settle_nx = '0;
                end
            end
            SETTLE: begin
                if (!lk_s) begin
                    state_nx  = WAIT_LOCK;
                    settle_nx = '0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nx  = RUN;
                    settle_nx = '0;
                end else begin
                    settle_nx = settle_cnt + SW'(1);
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_nx = WAIT_LOCK;
                end
            end
            default: begin
                state_nx  = WAIT_LOCK;
                settle_nx = '0;
            end
        endcase
        lost_nx = (state == RUN) && (state_nx == WAIT_LOCK);
    end

    // Outputs are decoded from next-state counter values so the registered
    // div_clk/tick line up with the registered cnt of the same cycle.
    always_comb begin
        clk_nx  = '0;
        tick_nx = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            cnt_nx[c]  = '0;
            dact_nx[c] = '0;
            half_nx[c] = '0;
            if (state_nx == RUN) begin
                if ((state != RUN) || resync || (dact[c] == '0) ||
                    (cnt[c] == dact[c] - W'(1))) begin
                    dact_nx[c] = div_val[c*W +: W];
                    cnt_nx[c]  = '0;
                end else begin
                    dact_nx[c] = dact[c];
                    cnt_nx[c]  = cnt[c] + W'(1);
                end
                half_nx[c] = (dact_nx[c] >> 1) + W'(dact_nx[c][0]);
                if (dact_nx[c] != '0) begin
                    clk_nx[c]  = (cnt_nx[c] < half_nx[c]);
                    tick_nx[c] = (cnt_nx[c] == dact_nx[c] - W'(1));
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            lk_m       <= 1'b0;
            lk_s       <= 1'b0;
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
            div_clk    <= '0;
            tick       <= '0;
            for (int unsigned c = 0; c < CH; c++) begin
                cnt[c]  <= '0;
                dact[c] <= '0;
            end
        end else begin
            lk_m       <= pll_locked;
            lk_s       <= lk_m;
            state      <= state_nx;
            settle_cnt <= settle_nx;
            ready      <= (state_nx == RUN);
            lock_lost  <= lost_nx;
            div_clk    <= clk_nx;
            tick       <= tick_nx;
            for (int unsigned c = 0; c < CH; c++) begin
                cnt[c]  <= cnt_nx[c];
                dact[c] <= dact_nx[c];
            end
        end
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised multi-channel clock-enable and divided-clock generator, successor to the single-output PLL wrapper. It sits directly behind the PLL output clock and gates all channels on a debounced PLL lock. It produces CH phase-aligned divided clocks and one-cycle tick enables, each with a runtime-programmable divisor. It also reports lock loss and supports an on-demand phase resync of all channels.

## Interface
- CH, 4, number of divider channels (1..16)
- W, 16, divisor width per channel
- LOCK_WAIT, 1024, consecutive synchronized-locked cycles required before running (>=1)

- sys_clk  input  1  PLL output clock; the only clock
- rst_n  input  1  reset, synchronous, active-low
- pll_locked  input  1  PLL lock, asynchronous to sys_clk
- resync  input  1  single-cycle request to restart all channels in phase
- div_val  input  CH*W  divisor for channel c in bits [c*W +: W]
- div_clk  output  CH  divided clock per channel, register-driven
- tick  output  CH  one-cycle enable per divided period
- ready  output  1  high while in RUN
- lock_lost  output  1  one-cycle pulse on RUN -> WAIT_LOCK

## Operation
- **Lock synchronization:** pll_locked passes through a 2-flop synchronizer to give lk_s. Reset clears both flops.
- **State machine:** WAIT_LOCK, SETTLE, RUN. Reset state is WAIT_LOCK with the settle counter at 0.
  - WAIT_LOCK: if lk_s = 1, go to SETTLE with the settle counter = 0.
  - SETTLE: if lk_s = 0, go to WAIT_LOCK. Else if the settle counter = LOCK_WAIT-1, go to RUN. Else increment the settle counter.
  - RUN: if lk_s = 0, go to WAIT_LOCK and pulse lock_lost for one cycle.
- **ready:** registered; equals (state == RUN).
- **Per-channel state:**
  - cnt, W bits.
  - D_act, W bits: the active divisor.
  - en: D_act != 0.
- **Divisor load:** D_act loads from div_val in these cases:
  - on the SETTLE -> RUN edge;
  - on any RUN cycle where resync = 1 (cnt also cleared to 0);
  - on the wrap edge, i.e. the edge ending a cycle with cnt = D_act-1.
- **Divisor changes:** a change of div_val mid-period takes effect only at the next wrap, so periods are never truncated or glitched. A disabled channel (D_act = 0) reloads every RUN cycle, so a nonzero write starts it on the next edge with cnt = 0.
- **Counting in RUN with en:** cnt increments; at D_act-1 it wraps to 0.
- **Outputs in RUN:** decoded from the next-state values and registered, so they align with cnt.
  - div_clk[c] = 1 iff cnt < ceil(D_act/2).
  - tick[c] = 1 iff cnt = D_act-1.
- **Divisor values:**
  - D = 1: div_clk held 1, tick held 1.
  - D = 2: toggles each cycle.
  - Odd D: high for (D+1)/2 cycles, low for (D-1)/2 cycles.
- **Disabled channel (D_act = 0):** cnt = 0, div_clk = 0, tick = 0.
- **Outside RUN:** all cnt = 0, all div_clk = 0, all tick = 0.
- **resync:** ignored outside RUN. On a RUN cycle it takes priority over wrap and restarts every channel in phase.
- **Lock lost mid-period:** outputs drop to 0 on the same edge that sets lock_lost. There is no completion of the current period.

## Timing
- **Reset values:** div_clk = 0, tick = 0, ready = 0, lock_lost = 0. Synchronizer and all counters at 0.
- **Lock-to-ready latency:** pll_locked first sampled high at edge e0 gives ready = 1 after edge e0 + LOCK_WAIT + 2, i.e. LOCK_WAIT + 3 edges counting e0.
- **Lock-drop latency:** pll_locked sampled low at edge e0 gives ready = 0 and lock_lost = 1 after e0 + 2.
- **Glitch filtering:** a glitch shorter than LOCK_WAIT synchronized cycles during SETTLE restarts the settle count.
- **First RUN cycle:** every enabled channel has cnt = 0 and div_clk = 1. tick is 1 only if D_act = 1.
- **Resync timing:** resync high at edge e makes cnt = 0 after e for all channels simultaneously.
- **Divisor change latency:** a new div_val is visible no earlier than the cycle after the current wrap.
- **Reset priority:** rst_n low at any edge returns to reset values on that edge, overriding all other inputs.

## Test plan
All scenarios use CH = 2, W = 8, LOCK_WAIT = 8.
- Lock and basic division:
  - Stimulus: reset, then pll_locked = 1 with div_val = {8'd5, 8'd4}.
  - Required: ready rises exactly 11 edges after the first high sample.
  - Required: ch0 div_clk pattern 1100 repeating with tick on every 4th cycle.
  - Required: ch1 div_clk pattern 11100 repeating with tick on every 5th cycle, both starting in phase.
- Settle glitch:
  - Stimulus: pll_locked high, then low for 2 cycles after 5 SETTLE cycles, then high.
  - Required: ready rises LOCK_WAIT + 3 edges after re-assertion; no early ready.
- Mid-period divisor change:
  - Stimulus: ch0 running D = 6; write D = 3 when cnt = 2.
  - Required: the current 6-cycle period completes (cnt reaches 5); the next period is 3 cycles (110) with no short pulse.
- Edge divisors:
  - Stimulus: div_val ch0 = 0, ch1 = 1.
  - Required: ch0 div_clk and tick stay 0; ch1 div_clk and tick stay 1.
  - Stimulus: write ch0 = 2.
  - Required: ch0 toggles starting next cycle with cnt = 0.
- Resync:
  - Stimulus: ch0 D = 4 and ch1 D = 7, free-running; pulse resync.
  - Required: next cycle both cnt = 0 and div_clk = 1, with no tick on that cycle; ignored when not in RUN.
- Lock loss and reset:
  - Stimulus: drop pll_locked in RUN.
  - Required: after 2 edges ready = 0, lock_lost high for exactly 1 cycle, all outputs 0.
  - Stimulus: assert rst_n = 0 mid-RUN.
  - Required: all outputs 0 after that edge, with lock_lost not pulsed.
